// File: rtl/motor_drive.sv
// motor_drive: H-bridge direction/PWM controller with input synchronisers,
// soft-start duty ramp and enforced dead-time on every stop or reversal.
// Both bridge legs are low whenever the FSM is outside RUN, and RUN only
// ever drives a latched direction of 10 or 01, so ain1/ain2 can never be 11.
// There is no valid/ready handshake here: in1/in2 are level commands that
// are sampled every clock after synchronisation.
module motor_drive #(
  parameter int DEAD_CYCLES = 1000,
  parameter int RAMP_CYCLES = 100,
  parameter int DUTY_MAX    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       in2,
  output logic       ain1,
  output logic       ain2,
  output logic       pwm_out,
  output logic [1:0] state,
  output logic [7:0] duty
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_CYCLES - 1);
  localparam logic [7:0]  DUTY_TOP  = 8'(DUTY_MAX);
  localparam logic [1:0]  CMD_FWD   = 2'b10;
  localparam logic [1:0]  CMD_REV   = 2'b01;

  logic        in1_m;
  logic        in1_s;
  logic        in2_m;
  logic        in2_s;
  logic [1:0]  cmd;
  logic        cmd_drive;
  logic [7:0]  pwm_cnt;
  state_t      fsm;
  logic [1:0]  dir;
  logic [15:0] ramp_cnt;
  logic [15:0] dead_cnt;

  // Two-flop synchronisers for the asynchronous direction command bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_m <= 1'b0;
      in1_s <= 1'b0;
      in2_m <= 1'b0;
      in2_s <= 1'b0;
    end else begin
      in1_m <= in1;
      in1_s <= in1_m;
      in2_m <= in2;
      in2_s <= in2_m;
    end
  end

  // 11 decodes as STOP, so only the two one-hot patterns request motion.
  assign cmd       = {in1_s, in2_s};
  assign cmd_drive = (cmd == CMD_FWD) || (cmd == CMD_REV);

  // Free-running PWM timebase; natural 8-bit wrap gives a 256-clock period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Control FSM with registered bridge outputs, soft-start ramp and dead-time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      dir      <= 2'b00;
      ain1     <= 1'b0;
      ain2     <= 1'b0;
      pwm_out  <= 1'b0;
      duty     <= 8'd0;
      ramp_cnt <= 16'd0;
      dead_cnt <= 16'd0;
    end else begin
      case (fsm)
        IDLE: begin
          ain1     <= 1'b0;
          ain2     <= 1'b0;
          pwm_out  <= 1'b0;
          duty     <= 8'd0;
          ramp_cnt <= 16'd0;
          dead_cnt <= 16'd0;
          if (cmd_drive) begin
            fsm          <= RUN;
            dir          <= cmd;
            {ain1, ain2} <= cmd;
          end
        end

        RUN: begin
          if (cmd == dir) begin
            {ain1, ain2} <= dir;
            pwm_out      <= (pwm_cnt < duty);
            if (ramp_cnt == RAMP_LAST) begin
              ramp_cnt <= 16'd0;
              if (duty < DUTY_TOP) begin
                duty <= duty + 8'd1;
              end
            end else begin
              ramp_cnt <= ramp_cnt + 16'd1;
            end
          end else begin
            // Stop or reversal: drop both legs and the enable on this edge.
            fsm      <= DEAD;
            ain1     <= 1'b0;
            ain2     <= 1'b0;
            pwm_out  <= 1'b0;
            duty     <= 8'd0;
            ramp_cnt <= 16'd0;
            dead_cnt <= 16'd0;
          end
        end

        DEAD: begin
          ain1     <= 1'b0;
          ain2     <= 1'b0;
          pwm_out  <= 1'b0;
          duty     <= 8'd0;
          ramp_cnt <= 16'd0;
          // Command is only looked at on the final dead-time clock.
          if (dead_cnt == DEAD_LAST) begin
            dead_cnt <= 16'd0;
            if (cmd_drive) begin
              fsm          <= RUN;
              dir          <= cmd;
              {ain1, ain2} <= cmd;
            end else begin
              fsm <= IDLE;
            end
          end else begin
            dead_cnt <= dead_cnt + 16'd1;
          end
        end

        default: begin
          // Illegal encoding: take the safe path through a full dead-time.
          fsm      <= DEAD;
          ain1     <= 1'b0;
          ain2     <= 1'b0;
          pwm_out  <= 1'b0;
          duty     <= 8'd0;
          ramp_cnt <= 16'd0;
          dead_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign state = fsm;

endmodule

// File: doc/motor_drive.md
MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 1000, meaning clocks both bridge inputs are held low on any stop or direction change (legal range 1..65535).
REQ-002 SHALL have parameter RAMP_CYCLES, default 100, meaning clocks between +1 duty steps during soft-start (legal range 1..65535).
REQ-003 SHALL have parameter DUTY_MAX, default 255, meaning the duty saturation value (legal range 0..255).
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port in1, input, 1, direction command bit A from the key-to-direction stage.
REQ-007 SHALL have port in2, input, 1, direction command bit B from the key-to-direction stage.
REQ-008 SHALL have port ain1, output, 1, H-bridge input A, registered.
REQ-009 SHALL have port ain2, output, 1, H-bridge input B, registered.
REQ-010 SHALL have port pwm_out, output, 1, H-bridge enable PWM, registered.
REQ-011 SHALL have port state, output, 2, FSM state: 00 IDLE, 01 RUN, 10 DEAD.
REQ-012 SHALL have port duty, output, 8, current duty value.

Function
REQ-013 SHALL pass in1 and in2 through a 2-flop synchroniser each; cmd = {in1_s, in2_s}, valid 2 clocks after the input change.
REQ-014 SHALL decode cmd as follows: 10 = FWD, 01 = REV, 00 = STOP, 11 = STOP (never drive both bridge legs).
REQ-015 SHALL keep a free-running 8-bit pwm_cnt, wrapping 255->0, giving a PWM period of 256 clocks.
REQ-016 SHALL register pwm_out = (state==RUN) && (pwm_cnt < duty): duty 0 gives constant low; duty 255 gives 255 high of 256.
REQ-017 In IDLE: ain1=ain2=0, duty=0; on cmd FWD or REV, latch dir=cmd and go to RUN next clock.
REQ-018 In RUN: {ain1,ain2} SHALL equal the latched dir.
REQ-019 In RUN: ramp_cnt SHALL count 0..RAMP_CYCLES-1; at terminal count duty SHALL increment by 1, saturating at DUTY_MAX, and ramp_cnt SHALL wrap to 0.
REQ-020 In RUN, when cmd equals dir: remain in RUN.
REQ-021 In RUN, when cmd is STOP or the opposite direction: go to DEAD next clock, clear duty to 0 and ramp_cnt to 0, and load dead_cnt=0.
REQ-022 In DEAD: ain1=ain2=0, pwm_out=0, dead_cnt increments each clock.
REQ-023 At dead_cnt==DEAD_CYCLES-1, the DEAD state SHALL sample cmd at that clock: FWD/REV -> latch dir=cmd, go to RUN with duty=0; STOP -> go to IDLE.
REQ-024 Command changes during DEAD SHALL be ignored except at the expiry sample; DEAD SHALL never be shortened.
REQ-025 A DEAD->RUN transition SHALL always restart soft-start from duty 0.
REQ-026 Outputs ain1/ain2 SHALL never be 11 in any state or clock.
REQ-027 Unused state encoding 11 SHALL recover to DEAD with dead_cnt=0.

Reset
REQ-028 While rst_n=0 all flops SHALL clear: state=IDLE, ain1=ain2=0, pwm_out=0, duty=0, pwm_cnt=0, ramp_cnt=0, dead_cnt=0, synchronisers=0.
REQ-029 Reset asserted mid-RUN SHALL drop ain1, ain2 and pwm_out immediately (asynchronously); after release the block SHALL start in IDLE with no dead-time.

Verification (bench params DEAD_CYCLES=4, RAMP_CYCLES=2, DUTY_MAX=8)
REQ-030 Stimulus: in1=1, in2=0 from IDLE. Required response: ain=10 three clocks later (2 sync + 1 FSM); duty steps 0->8 every 2 clocks, then holds at 8; pwm_out high 8 of every 256 clocks.
REQ-031 Stimulus: FWD in RUN, then switch to REV (01). Required response: state=DEAD, ain=00 and pwm_out=0 for exactly 4 clocks; then ain=01 and duty restarts from 0.
REQ-032 Stimulus: RUN, then cmd=11. Required response: treated as STOP; DEAD for 4 clocks, then IDLE; ain is never 11.
REQ-033 Stimulus: during DEAD, cmd toggles FWD->STOP->FWD with FWD present at expiry. Required response: DEAD lasts exactly 4 clocks, then RUN FWD.
REQ-034 Stimulus: rst_n pulsed low mid-ramp at duty=5. Required response: all outputs 0 asynchronously; after release state=IDLE, then RUN per cmd with duty from 0.
REQ-035 Stimulus: DUTY_MAX=0, FWD. Required response: ain=10, pwm_out constantly 0.
